// File: rtl/axis_rr_arb_pkg.sv
// Shared types and helpers for the packet-level round-robin AXI-Stream arbiter.
// Optional m_tdest output is enabled by defining AXIS_RR_ARB_TDEST_EN.
package axis_rr_arb_pkg;

    localparam int MAX_N_REQ = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PKT   = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // Index width never drops below one bit so a single requester still has a grant field.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_rr_select.sv
// Combinational round-robin picker: scans upward from the requester after last_grant, wrapping.
// Part of axis_rr_arb (optional AXIS_RR_ARB_TDEST_EN does not affect this block).
module rr_select
    import axis_rr_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] winner_onehot,
    output logic [IDX_W-1:0] winner_idx,
    output logic             any_req
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // First requester hit at offsets 1..N_REQ wins, so last_grant itself has lowest priority.
    always_comb begin
        winner_onehot = '0;
        winner_idx    = '0;
        found         = 1'b0;
        cand          = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = IDX_W'((32'(last_grant) + 32'(off)) % 32'(N_REQ));
            if (!found && req[cand]) begin
                found               = 1'b1;
                winner_idx          = cand;
                winner_onehot[cand] = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/axis_rr_arb.sv
// Packet-level round-robin arbiter sharing one registered AXI-Stream master among N_REQ requesters.
// Define AXIS_RR_ARB_TDEST_EN to add the registered m_tdest (granted index) output.
module axis_rr_arb
    import axis_rr_arb_pkg::*;
#(
    parameter  int N_REQ  = 4,
    parameter  int DATA_W = 32,
    localparam int IDX_W  = idx_w(N_REQ)
) (
    input  logic                    aclk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        s_tvalid,
    output logic [N_REQ-1:0]        s_tready,
    input  logic [N_REQ*DATA_W-1:0] s_tdata,
    input  logic [N_REQ-1:0]        s_tlast,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [DATA_W-1:0]       m_tdata,
    output logic                    m_tlast,
`ifdef AXIS_RR_ARB_TDEST_EN
    output logic [IDX_W-1:0]        m_tdest,
`endif
    output logic                    busy
);

    arb_state_t        state;
    logic [IDX_W-1:0]  grant;
    logic [IDX_W-1:0]  last_grant;
    logic [N_REQ-1:0]  grant_oh;
    logic [N_REQ-1:0]  winner_oh;
    logic [IDX_W-1:0]  winner_idx;
    logic              any_req;
    logic              out_ready;
    logic              sel_tvalid;
    logic              sel_tlast;
    logic [DATA_W-1:0] sel_tdata;
    logic              in_hs;
    logic              out_hs;

    rr_select #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_select (
        .req           (s_tvalid),
        .last_grant    (last_grant),
        .winner_onehot (winner_oh),
        .winner_idx    (winner_idx),
        .any_req       (any_req)
    );

    // The output register can take a new beat when empty or when its current beat leaves.
    assign out_ready  = !m_tvalid || m_tready;
    assign s_tready   = (state == PKT && out_ready) ? grant_oh : '0;
    assign sel_tvalid = |(s_tvalid & grant_oh);
    assign sel_tlast  = |(s_tlast & grant_oh);
    assign in_hs      = (state == PKT) && out_ready && sel_tvalid;
    assign out_hs     = m_tvalid && m_tready;
    assign busy       = (state != IDLE);

    always_comb begin
        sel_tdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_oh[i]) begin
                sel_tdata = sel_tdata | s_tdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Grant is held through the tlast beat; last_grant only advances once that beat has left.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            grant_oh   <= '0;
            last_grant <= IDX_W'(N_REQ - 1);
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            m_tlast    <= 1'b0;
`ifdef AXIS_RR_ARB_TDEST_EN
            m_tdest    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant    <= winner_idx;
                        grant_oh <= winner_oh;
                        state    <= PKT;
                    end
                end
                PKT: begin
                    if (in_hs && sel_tlast) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (in_hs) begin
                m_tvalid <= 1'b1;
                m_tdata  <= sel_tdata;
                m_tlast  <= sel_tlast;
`ifdef AXIS_RR_ARB_TDEST_EN
                m_tdest  <= grant;
`endif
            end else if (out_hs) begin
                m_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_rr_arb.sv
// Directed self-checking bench for axis_rr_arb (N_REQ=4, DATA_W=32).
// Also checks m_tdest when built with AXIS_RR_ARB_TDEST_EN.
module tb_axis_rr_arb;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int MAXC = 64;

    logic            aclk = 1'b0;
    logic            rst  = 1'b1;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tlast;
    logic            m_tvalid;
    logic            m_tready;
    logic [DW-1:0]   m_tdata;
    logic            m_tlast;
    logic            busy;
`ifdef AXIS_RR_ARB_TDEST_EN
    logic [1:0]      m_tdest;
    logic [1:0]      tr_dest [MAXC];
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] src_data [N][8];
    logic          src_last [N][8];
    int            src_len  [N];
    int            src_ptr  [N];
    int            src_off  [N];
    logic          mtr_pat  [MAXC];
    logic          rst_pat  [MAXC];

    logic          tr_valid  [MAXC];
    logic          tr_last   [MAXC];
    logic          tr_busy   [MAXC];
    logic [DW-1:0] tr_data   [MAXC];
    logic [N-1:0]  tr_sready [MAXC];

    logic [DW-1:0] cap_data [16];
    logic          cap_last [16];
    int            cap_cyc  [16];
    int            cap_n;

    axis_rr_arb #(
        .N_REQ  (N),
        .DATA_W (DW)
    ) dut (
        .aclk     (aclk),
        .rst      (rst),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tlast  (s_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast),
`ifdef AXIS_RR_ARB_TDEST_EN
        .m_tdest  (m_tdest),
`endif
        .busy     (busy)
    );

    always #5 aclk = ~aclk;

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0;
            src_ptr[i] = 0;
            src_off[i] = -1;
        end
        for (int c = 0; c < MAXC; c++) begin
            mtr_pat[c] = 1'b1;
            rst_pat[c] = 1'b0;
        end
    endtask

    task automatic add_beat(input int r, input logic [DW-1:0] d, input logic l);
        src_data[r][src_len[r]] = d;
        src_last[r][src_len[r]] = l;
        src_len[r]++;
    endtask

    // Cycle c: inputs change at the falling edge, outputs are sampled 1 time unit later.
    task automatic run(input int n);
        cap_n = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge aclk);
            rst      = rst_pat[c];
            m_tready = mtr_pat[c];
            for (int i = 0; i < N; i++) begin
                if (src_ptr[i] < src_len[i] && c != src_off[i]) begin
                    s_tvalid[i]          = 1'b1;
                    s_tdata[i*DW +: DW]  = src_data[i][src_ptr[i]];
                    s_tlast[i]           = src_last[i][src_ptr[i]];
                end else begin
                    s_tvalid[i]          = 1'b0;
                    s_tdata[i*DW +: DW]  = '0;
                    s_tlast[i]           = 1'b0;
                end
            end
            #1;
            tr_valid[c]  = m_tvalid;
            tr_last[c]   = m_tlast;
            tr_busy[c]   = busy;
            tr_data[c]   = m_tdata;
            tr_sready[c] = s_tready;
`ifdef AXIS_RR_ARB_TDEST_EN
            tr_dest[c]   = m_tdest;
`endif
            if (m_tvalid && m_tready && cap_n < 16) begin
                cap_data[cap_n] = m_tdata;
                cap_last[cap_n] = m_tlast;
                cap_cyc[cap_n]  = c;
                cap_n++;
            end
            for (int i = 0; i < N; i++) begin
                if (s_tvalid[i] && s_tready[i]) src_ptr[i]++;
            end
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        repeat (2) @(negedge aclk);
        checks++;
        if (m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_tvalid: got %b expected 0", m_tvalid); end
        checks++;
        if (m_tdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_m_tdata: got %h expected 0", m_tdata); end
        checks++;
        if (m_tlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_tlast: got %b expected 0", m_tlast); end
        checks++;
        if (s_tready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_s_tready: got %b expected 0000", s_tready); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
`ifdef AXIS_RR_ARB_TDEST_EN
        checks++;
        if (m_tdest !== 2'd0) begin errors++; $display("[TB] FAIL reset_m_tdest: got %0d expected 0", m_tdest); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [6:0]    ev;
        logic [6:0]    eb;
        logic [6:0]    es;
        logic [DW-1:0] ed [7];
        ev = 7'b0011100;
        eb = 7'b0011110;
        es = 7'b0001110;
        ed = '{32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h0, 32'h0};
        clear_sources();
        add_beat(0, 32'h11, 1'b0);
        add_beat(0, 32'h22, 1'b0);
        add_beat(0, 32'h33, 1'b1);
        run(7);
        for (int c = 0; c < 7; c++) begin
            checks++;
            if (tr_valid[c] !== ev[c]) begin errors++; $display("[TB] FAIL single_valid c%0d: got %b expected %b", c, tr_valid[c], ev[c]); end
            checks++;
            if (tr_busy[c] !== eb[c]) begin errors++; $display("[TB] FAIL single_busy c%0d: got %b expected %b", c, tr_busy[c], eb[c]); end
            checks++;
            if (tr_sready[c] !== {3'b000, es[c]}) begin errors++; $display("[TB] FAIL single_sready c%0d: got %b expected %b", c, tr_sready[c], {3'b000, es[c]}); end
            if (ev[c]) begin
                checks++;
                if (tr_data[c] !== ed[c]) begin errors++; $display("[TB] FAIL single_data c%0d: got %h expected %h", c, tr_data[c], ed[c]); end
                checks++;
                if (tr_last[c] !== (c == 4)) begin errors++; $display("[TB] FAIL single_last c%0d: got %b expected %b", c, tr_last[c], (c == 4)); end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] ed [5];
        int            ec [5];
        ed = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0};
        ec = '{2, 5, 8, 11, 14};
        @(negedge aclk);
        rst = 1'b1;
        @(negedge aclk);
        rst = 1'b0;
        clear_sources();
        add_beat(0, 32'hA0, 1'b1);
        add_beat(0, 32'hA0, 1'b1);
        add_beat(1, 32'hA1, 1'b1);
        add_beat(2, 32'hA2, 1'b1);
        add_beat(3, 32'hA3, 1'b1);
        run(17);
        checks++;
        if (cap_n !== 5) begin errors++; $display("[TB] FAIL rr_count: got %0d expected 5", cap_n); end
        for (int k = 0; k < 5 && k < cap_n; k++) begin
            checks++;
            if (cap_data[k] !== ed[k]) begin errors++; $display("[TB] FAIL rr_data %0d: got %h expected %h", k, cap_data[k], ed[k]); end
            checks++;
            if (cap_cyc[k] !== ec[k]) begin errors++; $display("[TB] FAIL rr_cycle %0d: got %0d expected %0d", k, cap_cyc[k], ec[k]); end
            checks++;
            if (cap_last[k] !== 1'b1) begin errors++; $display("[TB] FAIL rr_last %0d: got %b expected 1", k, cap_last[k]); end
        end
        for (int c = 0; c < 17; c++) begin
            checks++;
            if ($countones(tr_sready[c]) > 1) begin errors++; $display("[TB] FAIL rr_onehot c%0d: got %b expected at most one bit", c, tr_sready[c]); end
        end
    endtask

    task automatic test_hold_grant();
        logic [DW-1:0] ed [5];
        int            ec [5];
        ed = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h20};
        ec = '{2, 4, 5, 6, 9};
        clear_sources();
        for (int b = 0; b < 4; b++) add_beat(1, 32'h10 + 32'(b), (b == 3));
        add_beat(2, 32'h20, 1'b1);
        src_off[1] = 2;
        run(12);
        checks++;
        if (cap_n !== 5) begin errors++; $display("[TB] FAIL hold_count: got %0d expected 5", cap_n); end
        for (int k = 0; k < 5 && k < cap_n; k++) begin
            checks++;
            if (cap_data[k] !== ed[k]) begin errors++; $display("[TB] FAIL hold_data %0d: got %h expected %h", k, cap_data[k], ed[k]); end
            checks++;
            if (cap_cyc[k] !== ec[k]) begin errors++; $display("[TB] FAIL hold_cycle %0d: got %0d expected %0d", k, cap_cyc[k], ec[k]); end
            checks++;
            if (cap_last[k] !== (k >= 3)) begin errors++; $display("[TB] FAIL hold_last %0d: got %b expected %b", k, cap_last[k], (k >= 3)); end
        end
        checks++;
        if (tr_valid[3] !== 1'b0) begin errors++; $display("[TB] FAIL hold_bubble: got %b expected 0", tr_valid[3]); end
        for (int c = 0; c < 9; c++) begin
            checks++;
            if (tr_sready[c][2] !== (c == 8)) begin errors++; $display("[TB] FAIL hold_sready2 c%0d: got %b expected %b", c, tr_sready[c][2], (c == 8)); end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] ed [4];
        int            ec [4];
        ed = '{32'h01, 32'h02, 32'h03, 32'h04};
        ec = '{2, 4, 6, 8};
        clear_sources();
        for (int b = 0; b < 4; b++) add_beat(0, 32'h01 + 32'(b), (b == 3));
        for (int c = 0; c < MAXC; c++) mtr_pat[c] = (c % 2 == 0);
        run(11);
        checks++;
        if (cap_n !== 4) begin errors++; $display("[TB] FAIL bp_count: got %0d expected 4", cap_n); end
        for (int k = 0; k < 4 && k < cap_n; k++) begin
            checks++;
            if (cap_data[k] !== ed[k]) begin errors++; $display("[TB] FAIL bp_data %0d: got %h expected %h", k, cap_data[k], ed[k]); end
            checks++;
            if (cap_cyc[k] !== ec[k]) begin errors++; $display("[TB] FAIL bp_cycle %0d: got %0d expected %0d", k, cap_cyc[k], ec[k]); end
            checks++;
            if (cap_last[k] !== (k == 3)) begin errors++; $display("[TB] FAIL bp_last %0d: got %b expected %b", k, cap_last[k], (k == 3)); end
        end
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (tr_valid[2*k+1] !== 1'b1 || tr_data[2*k+1] !== ed[k]) begin
                errors++;
                $display("[TB] FAIL bp_stall c%0d: got valid %b data %h expected valid 1 data %h", 2*k+1, tr_valid[2*k+1], tr_data[2*k+1], ed[k]);
            end
        end
        checks++;
        if (tr_sready[3] !== 4'b0000) begin errors++; $display("[TB] FAIL bp_sready_stall: got %b expected 0000", tr_sready[3]); end
    endtask

    task automatic test_reset_mid_packet();
        clear_sources();
        for (int b = 0; b < 4; b++) add_beat(1, 32'h41 + 32'(b), (b == 3));
        rst_pat[3] = 1'b1;
        run(4);
        checks++;
        if (tr_valid[2] !== 1'b1 || tr_data[2] !== 32'h41) begin
            errors++;
            $display("[TB] FAIL mid_beat1: got valid %b data %h expected valid 1 data 41", tr_valid[2], tr_data[2]);
        end
        checks++;
        if (tr_valid[3] !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid: got %b expected 0", tr_valid[3]); end
        checks++;
        if (tr_data[3] !== 32'h0) begin errors++; $display("[TB] FAIL mid_rst_data: got %h expected 0", tr_data[3]); end
        checks++;
        if (tr_busy[3] !== 1'b0 || tr_sready[3] !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL mid_rst_idle: got busy %b sready %b expected busy 0 sready 0000", tr_busy[3], tr_sready[3]);
        end
        clear_sources();
        add_beat(0, 32'h50, 1'b1);
        add_beat(1, 32'h60, 1'b1);
        run(8);
        checks++;
        if (cap_n !== 2) begin errors++; $display("[TB] FAIL mid_after_count: got %0d expected 2", cap_n); end
        checks++;
        if (cap_data[0] !== 32'h50 || cap_cyc[0] !== 2) begin
            errors++;
            $display("[TB] FAIL mid_after_first: got %h at c%0d expected 50 at c2", cap_data[0], cap_cyc[0]);
        end
        checks++;
        if (cap_data[1] !== 32'h60 || cap_cyc[1] !== 5) begin
            errors++;
            $display("[TB] FAIL mid_after_second: got %h at c%0d expected 60 at c5", cap_data[1], cap_cyc[1]);
        end
    endtask

    task automatic test_tdest();
        clear_sources();
        add_beat(3, 32'h70, 1'b0);
        add_beat(3, 32'h71, 1'b1);
        run(6);
        checks++;
        if (cap_n !== 2) begin errors++; $display("[TB] FAIL req3_count: got %0d expected 2", cap_n); end
        checks++;
        if (cap_data[0] !== 32'h70 || cap_cyc[0] !== 2 || cap_last[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL req3_beat0: got %h c%0d last %b expected 70 c2 last 0", cap_data[0], cap_cyc[0], cap_last[0]);
        end
        checks++;
        if (cap_data[1] !== 32'h71 || cap_cyc[1] !== 3 || cap_last[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL req3_beat1: got %h c%0d last %b expected 71 c3 last 1", cap_data[1], cap_cyc[1], cap_last[1]);
        end
`ifdef AXIS_RR_ARB_TDEST_EN
        for (int c = 2; c < 4; c++) begin
            checks++;
            if (tr_dest[c] !== 2'd3) begin errors++; $display("[TB] FAIL tdest c%0d: got %0d expected 3", c, tr_dest[c]); end
        end
`endif
    endtask

    initial begin
        $display("[TB] starting axis_rr_arb bench");
        test_reset();
        test_single();
        test_round_robin();
        test_hold_grant();
        test_backpressure();
        test_reset_mid_packet();
        test_tdest();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_rr_arb.md
# axis_rr_arb

Round-robin, packet-level arbiter sharing one AXI-Stream master link among N_REQ AXI-Stream requesters. Locks a grant for a whole packet (through the beat carrying s_tlast), forwards beats through a single registered output stage, then rearbitrates. Sits between per-channel producers and the single downstream AXIS slave.

## Interface
- N_REQ, 4: number of requesters, 1..16
- DATA_W, 32: tdata width
- aclk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- s_tvalid  in  N_REQ  per-requester valid
- s_tready  out  N_REQ  per-requester ready; at most one bit high
- s_tdata  in  N_REQ*DATA_W  requester i on bits [i*DATA_W +: DATA_W]
- s_tlast  in  N_REQ  per-requester end of packet
- m_tvalid  out  1  output valid, registered
- m_tready  in  1  downstream ready
- m_tdata  out  DATA_W  output data, registered
- m_tlast  out  1  output end of packet, registered
- m_tdest  out  IDX_W=max(1,clog2(N_REQ))  granted index; present only with AXIS_RR_ARB_TDEST_EN
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, PKT, DRAIN.
- IDLE: if any s_tvalid, select winner by round-robin: scan from (last_grant+1) mod N_REQ upward, wrapping; winner captured in grant register; go PKT. No s_tready in IDLE.
- PKT: s_tready[grant] = !m_tvalid || m_tready; other s_tready bits 0. Input handshake loads m_tdata/m_tlast (and m_tdest) from the granted requester and sets m_tvalid. Input handshake with s_tlast=1 -> DRAIN.
- DRAIN: all s_tready 0; on m_tvalid && m_tready -> IDLE, last_grant <= grant.
- Output stage: m_tvalid cleared on output handshake when no new input beat accepted same cycle; set when input beat accepted. Simultaneous output and input handshake in PKT: register reloads, m_tvalid stays 1.
- Held grant: granted requester dropping s_tvalid mid-packet keeps grant; no timeout, no preemption.
- Requests from others during PKT/DRAIN wait; their s_tready stay 0.
- N_REQ=1: arbitration degenerates to index 0; protocol unchanged.

## Timing
- Reset values: s_tready 0, m_tvalid 0, m_tdata 0, m_tlast 0, m_tdest 0, busy 0, state IDLE, last_grant N_REQ-1 (requester 0 wins first).
- s_tvalid high in IDLE at cycle 0 -> PKT at cycle 1, s_tready[grant] high in cycle 1 -> m_tvalid high cycle 2 (2-cycle latency).
- Within packet: 1 beat/cycle with m_tready held high.
- Packet gap: last output handshake at cycle k -> IDLE cycle k+1 -> next grant's first s_tready cycle k+2.
- m_tdata/m_tlast/m_tdest stable while m_tvalid && !m_tready.
- Reset asserted mid-packet: all state and outputs return to reset values asynchronously; partial packet discarded; arbitration restarts at requester 0.

## Configuration
- AXIS_RR_ARB_TDEST_EN defined: m_tdest port exists, registered with each output beat, equals grant index.
- Undefined: no m_tdest port, no tdest register; all other behaviour identical.

## Structure
- Package axis_rr_arb_pkg: state enum (IDLE, PKT, DRAIN), IDX_W computation function, max N_REQ constant.
- Sub-module rr_select: combinational; inputs request vector and last_grant, outputs one-hot winner, index, any-request flag. Top holds FSM, grant register, output stage.

## Test plan
- Single requester 0 sends 3-beat packet 0x11,0x22,0x33 (last on 0x33), m_tready=1 -> m_tvalid first at cycle 2, data in order, m_tlast only with 0x33, then IDLE.
- Requesters 0–3 all valid, 1-beat packets 0xA0+i -> output order 0xA0,0xA1,0xA2,0xA3,0xA0; 3-cycle spacing per packet.
- Requester 1 holds 4-beat packet while requester 2 requests -> no requester-2 beat until requester-1 last beat leaves; s_tready[2] stays 0.
- m_tready toggled 1010 during 4-beat packet 0x01..0x04 -> no beat lost/duplicated; m_tdata stable while stalled.
- rst pulsed during beat 2 of a 4-beat packet -> m_tvalid 0 immediately, next grant goes to requester 0 if valid.
- With AXIS_RR_ARB_TDEST_EN, requester 3 packet -> m_tdest=3 on every beat; without macro, port absent and build clean.
